// File: rtl/rac_seg.sv
`default_nettype none
// ============================================================================
// Module      : rac_seg
// Description : Multi-cycle segmented ripple-carry adder/subtractor. Processes
//               one SEG-bit slice per clock, LSB slice first, carrying between
//               slices in a register. Start/busy/done handshake with a held
//               result, raw MSB carry-out and two's-complement overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rac_seg #(
    parameter int WIDTH = 24,
    parameter int SEG   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             ovf
);

    localparam int c_NSEG = WIDTH / SEG;
    localparam int c_CW   = (c_NSEG > 1) ? $clog2(c_NSEG) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NSEG - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic             r_carry;
    // Operands are shifted right one slice per cycle so the active slice is
    // always at the bottom; this keeps the adder a fixed SEG-bit chain.
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [SEG:0]         w_seg_sum;
    logic [WIDTH+SEG-1:0] w_res_cat;
    logic [WIDTH-1:0]     w_res_next;
    logic                 w_ovf;

    // One SEG-bit full-adder chain, reused for every slice.
    always_comb begin
        w_seg_sum  = {1'b0, r_opa[SEG-1:0]} + {1'b0, r_opb[SEG-1:0]}
                   + {{SEG{1'b0}}, r_carry};
        // New slice enters at the top; after NSEG slices the result is aligned.
        w_res_cat  = {w_seg_sum[SEG-1:0], r_res};
        w_res_next = w_res_cat[WIDTH+SEG-1:SEG];
        // On the last slice the bottom of the shifted operands holds the MSBs.
        w_ovf      = (r_opa[SEG-1] == r_opb[SEG-1]) &&
                     (w_seg_sum[SEG-1] != r_opa[SEG-1]);
    end

    // Control FSM and slice datapath, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= b ^ {WIDTH{sub}};
                        r_carry <= Cin ^ sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_seg_sum[SEG];
                    r_opa   <= r_opa >> SEG;
                    r_opb   <= r_opb >> SEG;
                    if (r_cnt == c_LAST) begin
                        r_c     <= w_seg_sum[SEG];
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign r    = r_res;
    assign c    = r_c;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
